// File: rtl/rr_arb6.sv
// Six-requester round-robin arbiter: registered one-hot grant held until release.
// Optional grant watchdog compiled in with `define RR_ARB6_TIMEOUT_EN.
module rr_arb6 #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] req,
  input  logic       done,
  output logic [5:0] gnt,
  output logic [2:0] gnt_num,
  output logic       gnt_vld,
  output logic       to_err
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t     state_reg, state_next;
  logic [5:0] gnt_reg, gnt_next;
  logic [2:0] num_reg, num_next;
  logic [2:0] last_reg, last_next;
  logic [5:0] above;
  logic [5:0] mask;
  logic [2:0] winner;
  logic       rel;

  // Six-bit find-last-one encoder: lowest set bit wins, 0 when empty.
  function automatic logic [2:0] fl1(input logic [5:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_above
      assign above[gi] = (3'(gi) > last_reg);
    end
  endgenerate

  assign mask   = req & above;
  assign winner = (|mask) ? fl1(mask) : fl1(req);
  assign rel    = done | ~(|(req & gnt_reg));

`ifdef RR_ARB6_TIMEOUT_EN
  logic [15:0] wdog_reg, wdog_next;
  logic        to_err_reg, to_err_next;
`endif

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    num_next   = num_reg;
    last_next  = last_reg;
`ifdef RR_ARB6_TIMEOUT_EN
    wdog_next   = wdog_reg;
    to_err_next = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next = OWN;
          gnt_next   = 6'(1) << winner;
          num_next   = winner;
          last_next  = winner;
`ifdef RR_ARB6_TIMEOUT_EN
          wdog_next  = 16'd0;
`endif
        end
      end
      OWN: begin
        // A normal release takes precedence over a coincident timeout.
        if (rel) begin
          state_next = IDLE;
          gnt_next   = 6'd0;
          num_next   = 3'd7;
        end
`ifdef RR_ARB6_TIMEOUT_EN
        else if (wdog_reg == 16'(TIMEOUT - 1)) begin
          state_next  = IDLE;
          gnt_next    = 6'd0;
          num_next    = 3'd7;
          to_err_next = 1'b1;
        end else begin
          wdog_next = wdog_reg + 16'd1;
        end
`endif
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 6'd0;
        num_next   = 3'd7;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      gnt_reg   <= 6'd0;
      num_reg   <= 3'd7;
      last_reg  <= 3'd5;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      num_reg   <= num_next;
      last_reg  <= last_next;
    end
  end

`ifdef RR_ARB6_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_reg   <= 16'd0;
      to_err_reg <= 1'b0;
    end else begin
      wdog_reg   <= wdog_next;
      to_err_reg <= to_err_next;
    end
  end
  assign to_err = to_err_reg;
`else
  assign to_err = 1'b0;
`endif

  assign gnt     = gnt_reg;
  assign gnt_num = num_reg;
  assign gnt_vld = |gnt_reg;

endmodule

// File: tb/tb_rr_arb6.sv
// Scoreboard bench for rr_arb6: spec-level model pushes expected winners, a negedge
// monitor pops them on each new grant and checks every output each cycle.
module tb_rr_arb6;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] req = 6'd0;
  logic       done = 1'b0;
  logic [5:0] gnt;
  logic [2:0] gnt_num;
  logic       gnt_vld;
  logic       to_err;

  int checks = 0;
  int failures = 0;

  rr_arb6 #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_num(gnt_num), .gnt_vld(gnt_vld), .to_err(to_err)
  );

  always #5 clk = ~clk;

  // Reference model state: who owns, the last winner, cycles owned so far.
  bit m_own = 1'b0;
  int m_idx = 0;
  int m_last = 5;
  int m_hold = 0;
  bit m_to = 1'b0;
  int exp_q[$];
  int seen[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Rotated priority: scan upward starting just above the previous winner.
  function automatic int rr_pick(input logic [5:0] r, input int last);
    for (int k = 1; k <= 6; k++) begin
      if (r[(last + k) % 6]) return (last + k) % 6;
    end
    return -1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_own = 1'b0; m_last = 5; m_hold = 0; m_to = 1'b0;
        exp_q.delete();
      end else begin
        m_to = 1'b0;
        if (!m_own) begin
          if (req != 6'd0) begin
            m_idx = rr_pick(req, m_last);
            m_last = m_idx;
            m_own = 1'b1;
            m_hold = 0;
            exp_q.push_back(m_idx);
          end
        end else if (done || !req[m_idx]) begin
          m_own = 1'b0;
        end else begin
`ifdef RR_ARB6_TIMEOUT_EN
          if (m_hold == TO - 1) begin
            m_own = 1'b0;
            m_to = 1'b1;
          end else m_hold++;
`else
          m_hold++;
`endif
        end
      end
    end
  end

  // Monitor: per-cycle output checks plus scoreboard pop on each new grant.
  initial begin
    bit prev_vld;
    int w;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      chk("gnt_vld", int'(gnt_vld), int'(m_own));
      chk("gnt", int'(gnt), m_own ? (1 << m_idx) : 0);
      chk("gnt_num", int'(gnt_num), m_own ? m_idx : 7);
      chk("to_err", int'(to_err), int'(m_to));
      if (gnt_vld && !prev_vld) begin
        if (exp_q.size() == 0) begin
          chk("grant_unexpected", int'(gnt_num), -1);
        end else begin
          w = exp_q.pop_front();
          chk("sb_winner", int'(gnt_num), w);
          seen.push_back(int'(gnt_num));
        end
      end
      prev_vld = gnt_vld;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    while (!gnt_vld && n < 20) begin
      cycle();
      n++;
    end
    if (!gnt_vld) chk("grant_timeout", 0, 1);
  endtask

  task automatic release_all();
    done = 1'b1;
    req = 6'd0;
    cycle();
    done = 1'b0;
    cycle();
  endtask

  initial begin
    int exp_seq[7];
    exp_seq = '{0, 1, 2, 3, 4, 5, 0};

    #1 rst_n = 1'b0;
    repeat (3) cycle();
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_num", int'(gnt_num), 7);
    chk("rst_vld", int'(gnt_vld), 0);
    chk("rst_to_err", int'(to_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // All masters requesting: plain rotation 0..5 then wrap to 0.
    req = 6'b111111;
    for (int g = 0; g < 7; g++) begin
      wait_grant();
      done = 1'b1;
      cycle();
      done = 1'b0;
    end
    req = 6'd0;
    cycle();
    if (seen.size() >= 7) begin
      for (int i = 0; i < 7; i++) chk("rotation", seen[i], exp_seq[i]);
    end else chk("rotation_count", seen.size(), 7);

    // Single requester, then withdrawal.
    req = 6'b001000;
    cycle();
    chk("single_gnt", int'(gnt), 8);
    chk("single_num", int'(gnt_num), 3);
    req = 6'd0;
    cycle();
    chk("withdraw_gnt", int'(gnt), 0);
    chk("withdraw_num", int'(gnt_num), 7);

    // Wrap: last=4 -> winner 0; then last=0 with 100001 -> winner 5.
    req = 6'b010000;
    cycle();
    done = 1'b1; req = 6'd0;
    cycle();
    done = 1'b0; req = 6'b000011;
    cycle();
    chk("wrap_num0", int'(gnt_num), 0);
    done = 1'b1; req = 6'b100001;
    cycle();
    done = 1'b0;
    cycle();
    chk("wrap_num5", int'(gnt_num), 5);
    release_all();

    // Non-owner churn while master 2 owns.
    req = 6'b000100;
    cycle();
    chk("churn_start", int'(gnt), 4);
    for (int i = 0; i < 3; i++) begin
      req[0] = ~req[0];
      req[5] = ~req[5];
      cycle();
      chk("churn_hold", int'(gnt), 4);
    end
    release_all();

    // Asynchronous reset between edges while master 4 owns.
    req = 6'b010000;
    cycle();
    chk("pre_rst_gnt", int'(gnt), 16);
    #3 rst_n = 1'b0;
    #1;
    chk("async_gnt", int'(gnt), 0);
    chk("async_num", int'(gnt_num), 7);
    chk("async_vld", int'(gnt_vld), 0);
    #2 req = 6'b010001;
    rst_n = 1'b1;
    cycle();
    chk("post_rst_num", int'(gnt_num), 0);
    release_all();

`ifdef RR_ARB6_TIMEOUT_EN
    // Watchdog: master 1 never finishes.
    req = 6'b000010;
    cycle();
    chk("wd_gnt", int'(gnt), 2);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("wd_hold", int'(gnt), 2);
      chk("wd_no_err", int'(to_err), 0);
    end
    cycle();
    req = 6'b000011;
    chk("wd_revoke", int'(gnt), 0);
    chk("wd_to_err", int'(to_err), 1);
    cycle();
    chk("wd_next0", int'(gnt_num), 0);
    chk("wd_err_pulse", int'(to_err), 0);
    done = 1'b1;
    cycle();
    done = 1'b0;
    cycle();
    chk("wd_next1", int'(gnt_num), 1);
    release_all();
`endif

    // Randomized traffic with sparse request toggles and random done.
    for (int i = 0; i < 400; i++) begin
      req = req ^ 6'($urandom & $urandom & $urandom);
      done = ($urandom_range(0, 3) == 0);
      cycle();
    end
    release_all();
    cycle();
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
